led_indicator_sequencer: RTL

LED_INDICATOR_SEQUENCER -- requirements
Module: led_indicator_sequencer

---
 rtl/led_indicator_sequencer_if.sv | 9 +
 rtl/led_indicator_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/led_indicator_sequencer_if.sv
// Colour-detector handshake: detector offers color/color_valid, sequencer answers color_ready.
interface led_indicator_sequencer_if;
  logic [1:0] color;
  logic       color_valid;
  logic       color_ready;

  modport master (output color, output color_valid, input color_ready);
  modport slave  (input color, input color_valid, output color_ready);
endinterface

// File: rtl/led_indicator_sequencer.sv
// Three-slot colour indicator with hold-off guard, FULL lock and end-of-run blink.
// Optional build macro LED_DIM_EN gates all LEDs to a 25% duty cycle.

module led_slot_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [2:0] wdata,
  input  logic       blink,
  input  logic       blink_lit,
  input  logic       dim_on,
  output logic [2:0] led
);
  logic [2:0] slot_q;

  always_ff @(posedge clk) begin
    if (rst || clr) slot_q <= 3'b000;
    else if (we)    slot_q <= wdata;
  end

  assign led = (blink ? (blink_lit ? 3'b010 : 3'b000) : slot_q) & {3{dim_on}};
endmodule

module led_indicator_sequencer #(
  parameter int HOLDOFF_CYCLES = 12000,
  parameter int BLINK_HALF     = 2000
) (
  input  logic       clk,
  input  logic       rst,
  led_indicator_sequencer_if.slave det,
  input  logic       endofrun,
  input  logic       clear,
  output logic [2:0] led1,
  output logic [2:0] led2,
  output logic [2:0] led3,
  output logic [1:0] indicator,
  output logic [1:0] slots_used,
  output logic       busy
);
  localparam int NUM_SLOTS = 3;
  localparam logic [14:0] HOLD_LAST  = 15'(HOLDOFF_CYCLES - 1);
  localparam logic [14:0] BLINK_LAST = 15'(BLINK_HALF - 1);

  typedef enum logic [1:0] {IDLE, HOLDOFF, FULL, BLINK} state_t;

  state_t state_q, state_d;
  logic [14:0] hold_cnt_q, hold_cnt_d;
  logic [14:0] blink_cnt_q, blink_cnt_d;
  logic        blink_ph_q, blink_ph_d;
  logic        xfer, xfer_col, wr_slot, slot_clr, dim_on;
  logic [2:0]  wdata;
  logic [NUM_SLOTS-1:0]       we;
  logic [NUM_SLOTS-1:0][2:0]  led_v;

  assign det.color_ready = (state_q == IDLE) && !clear && !endofrun && !rst;
  assign xfer     = det.color_valid && det.color_ready;
  assign xfer_col = xfer && (det.color != 2'b00);
  // Reachable only after a blink leaves IDLE with all slots full: consumed, never overwrites.
  assign wr_slot  = xfer_col && (slots_used != 2'd3);
  assign slot_clr = clear && !endofrun;
  assign busy     = (state_q != IDLE);

  always_comb begin
    wdata = 3'b000;
    case (det.color)
      2'b01:   wdata = 3'b001;
      2'b10:   wdata = 3'b100;
      2'b11:   wdata = 3'b010;
      default: wdata = 3'b000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = 15'd0;
    blink_cnt_d = 15'd0;
    blink_ph_d  = 1'b0;
    if (endofrun) begin
      state_d = BLINK;
      if (state_q == BLINK) begin
        blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? 15'd0 : blink_cnt_q + 15'd1;
        blink_ph_d  = (blink_cnt_q == BLINK_LAST) ? !blink_ph_q : blink_ph_q;
      end
    end else if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (xfer_col) state_d = (slots_used >= 2'd2) ? FULL : HOLDOFF;
        HOLDOFF: begin
          if (hold_cnt_q == HOLD_LAST) state_d = IDLE;
          else                         hold_cnt_d = hold_cnt_q + 15'd1;
        end
        FULL:    state_d = FULL;
        BLINK:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_cnt_q  <= 15'd0;
      blink_cnt_q <= 15'd0;
      blink_ph_q  <= 1'b0;
      slots_used  <= 2'd0;
      indicator   <= 2'b00;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      if (slot_clr) begin
        slots_used <= 2'd0;
        indicator  <= 2'b00;
      end else if (wr_slot) begin
        slots_used <= slots_used + 2'd1;
        indicator  <= det.color;
      end
    end
  end

`ifdef LED_DIM_EN
  logic [1:0] dim_cnt;
  always_ff @(posedge clk) begin
    if (rst) dim_cnt <= 2'd0;
    else     dim_cnt <= dim_cnt + 2'd1;
  end
  assign dim_on = (dim_cnt == 2'd0);
`else
  assign dim_on = 1'b1;
`endif

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_lane
    assign we[g] = wr_slot && (slots_used == 2'(g));
    led_slot_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr       (slot_clr),
      .we        (we[g]),
      .wdata     (wdata),
      .blink     (state_q == BLINK),
      .blink_lit (blink_ph_q),
      .dim_on    (dim_on),
      .led       (led_v[g])
    );
  end

  assign led1 = led_v[0];
  assign led2 = led_v[1];
  assign led3 = led_v[2];
endmodule
